pool2x2: RTL

Streaming 2×2, stride-2 pooling stage directly downstream of the 2D convolution block. It consumes the convolution's raster-order, one-sample-per-cycle signed 16-bit output stream of an `image_size`×`image_size` frame. It emits a `floor(n/2)`×`floor(n/2)` pooled frame in raster order, using a half-row line buffer and no frame storage.

---
 rtl/pool2x2.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pool2x2.sv
// pool2x2 - streaming 2x2, stride-2 pooling of a raster-order signed 16-bit
// frame of image_size x image_size samples. Uses a half-row line buffer only.
// Optional feature macro: POOL_AVG_EN adds the pool_mode port and the average
// datapath (17-bit line buffer); without it the block is max-only.
module pool2x2 (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         image_size,
`ifdef POOL_AVG_EN
  input  logic               pool_mode,
`endif
  input  logic               in_valid,
  input  logic signed [15:0] in_data,
  output logic               out_valid,
  output logic signed [15:0] out_data,
  output logic               out_last
);

`ifdef POOL_AVG_EN
  localparam int BUF_W = 17;
`else
  localparam int BUF_W = 16;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state_reg, state_next;
  logic [3:0] n_reg, n_next;
  logic [3:0] row_reg, row_next;
  logic [3:0] col_reg, col_next;

  // Position and frame size of the sample being accepted this cycle
  logic       accept;
  logic [3:0] cur_row, cur_col, cur_n;
  logic [3:0] n_even;
  logic       in_region;
  logic       fire;
  logic       fire_last;

  // Pairing / line buffer datapath
  logic signed [15:0]      h_reg;
  logic signed [BUF_W-1:0] buf_mem [0:6];
  logic signed [BUF_W-1:0] buf_rd_reg;
  logic signed [15:0]      pair_max;
  logic signed [BUF_W-1:0] pair_ext;
  logic signed [BUF_W-1:0] win_max;
  logic signed [BUF_W-1:0] p_val;
  logic signed [15:0]      result;

`ifdef POOL_AVG_EN
  logic                    mode_reg, mode_next;
  logic signed [16:0]      pair_sum;
  logic signed [17:0]      win_sum;
  logic                    unused_bits;
  // Low sum bits are shifted away; the top bit of win_max is pure sign.
  assign unused_bits = ^{win_sum[1:0], win_max[BUF_W-1]};
`endif

  // Next-state: frame start, raster counters, return to IDLE after last sample
  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    row_next   = row_reg;
    col_next   = col_reg;
`ifdef POOL_AVG_EN
    mode_next  = mode_reg;
`endif
    accept     = 1'b0;
    cur_row    = row_reg;
    cur_col    = col_reg;
    cur_n      = n_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid && (image_size >= 4'd2)) begin
          accept     = 1'b1;
          cur_n      = image_size;
          cur_row    = 4'd0;
          cur_col    = 4'd0;
          n_next     = image_size;
`ifdef POOL_AVG_EN
          mode_next  = pool_mode;
`endif
          state_next = RUN;
        end
      end
      RUN: begin
        accept = in_valid;
      end
      default: state_next = IDLE;
    endcase
    if (accept) begin
      if (cur_col == cur_n - 4'd1) begin
        col_next = 4'd0;
        if (cur_row == cur_n - 4'd1) begin
          row_next   = 4'd0;
          state_next = IDLE;
        end else begin
          row_next = cur_row + 4'd1;
        end
      end else begin
        col_next = cur_col + 4'd1;
      end
    end
  end

  // Odd trailing row/column are outside the pooled region and are discarded
  always_comb begin
    n_even    = {cur_n[3:1], 1'b0};
    in_region = (cur_row < n_even) && (cur_col < n_even);
    fire      = accept && in_region && cur_row[0] && cur_col[0];
    fire_last = fire && (cur_row == n_even - 4'd1) && (cur_col == n_even - 4'd1);
  end

  // Pair value and window result for the selected pooling mode
  always_comb begin
    pair_max = (h_reg > in_data) ? h_reg : in_data;
    pair_ext = BUF_W'(pair_max);
    win_max  = (buf_rd_reg > pair_ext) ? buf_rd_reg : pair_ext;
    p_val    = pair_ext;
    result   = win_max[15:0];
`ifdef POOL_AVG_EN
    pair_sum = {h_reg[15], h_reg} + {in_data[15], in_data};
    win_sum  = {buf_rd_reg[16], buf_rd_reg} + {pair_sum[16], pair_sum};
    if (mode_reg) begin
      p_val  = pair_sum;
      // Arithmetic shift of the 4-sample sum: floor average, always fits 16 bits
      result = win_sum[17:2];
    end
`endif
  end

  // Control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= 4'd0;
      row_reg   <= 4'd0;
      col_reg   <= 4'd0;
`ifdef POOL_AVG_EN
      mode_reg  <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      row_reg   <= row_next;
      col_reg   <= col_next;
`ifdef POOL_AVG_EN
      mode_reg  <= mode_next;
`endif
    end
  end

  // Even column holds the sample and prefetches the line buffer entry for the
  // window; odd column of an even row writes the pair into the line buffer.
  always_ff @(posedge clk) begin
    if (accept && in_region) begin
      if (!cur_col[0]) begin
        h_reg      <= in_data;
        buf_rd_reg <= buf_mem[cur_col[3:1]];
      end else if (!cur_row[0]) begin
        buf_mem[cur_col[3:1]] <= p_val;
      end
    end
  end

  // Registered pooled output, zero when not valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= 16'sd0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= fire;
      out_data  <= fire ? result : 16'sd0;
      out_last  <= fire_last;
    end
  end

endmodule
